// File: rtl/edge_detect_pkg.sv
// Shared types and default sizing for the edge detector bank.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int DEF_CHANNELS        = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/edge_detect_channel.sv
// One input channel: synchroniser, debounce filter, edge qualification,
// registered edge pulse and sticky/overflow event flags.
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       level,
  output logic       edg,
  output logic       sticky,
  output logic       overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   edg_q, edg_d;
  logic                   sticky_q, sticky_d;
  logic                   ovf_q, ovf_d;
  logic                   sy;
  logic                   ev;

  assign sy = sync_q[SYNC_STAGES-1];

  // Next-state: shift synchroniser, run debounce count, qualify accepted
  // transitions against mode, update event flags (event beats clear).
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    cnt_d    = cnt_q;
    level_d  = level_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    ev       = 1'b0;

    if (sy == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sy;
      cnt_d   = '0;
      case (mode)
        EDGE_RISE: ev = sy;
        EDGE_FALL: ev = ~sy;
        EDGE_BOTH: ev = 1'b1;
        default:   ev = 1'b0;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    edg_d = ev;

    if (ev && sticky_q && !clr) begin
      ovf_d = 1'b1;
    end else if (ev) begin
      sticky_d = 1'b1;
      if (clr) ovf_d = 1'b0;
    end else if (clr) begin
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      edg_q    <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      edg_q    <= edg_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level    = level_q;
  assign edg      = edg_q;
  assign sticky   = sticky_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of independent edge detector channels with a combined event flag.
module edge_detect_bank
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edg,
  output logic [CHANNELS-1:0]   sticky,
  output logic [CHANNELS-1:0]   overflow,
  output logic                  any_edg
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_in  (sig_in[i]),
      .mode    (edge_mode_t'(mode[2*i +: 2])),
      .clr     (clr[i]),
      .level   (level[i]),
      .edg     (edg[i]),
      .sticky  (sticky[i]),
      .overflow(overflow[i])
    );
  end

  assign any_edg = |edg;

endmodule

// File: doc/edge_detect_bank.md
Name: edge_detect_bank

Overview:
- Multi-channel, parametrised edge detector for asynchronous board inputs: buttons, switches and the UART RX line.
- Per channel, in order:
  - synchronises the input;
  - debounces it;
  - detects rising, falling or both edges according to a per-channel mode;
  - emits a one-cycle pulse.
- Also keeps per-channel sticky and overflow flags so slower control FSMs can poll for events.
- Sits between top-level input pins and the UART/control logic.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synchronised level must hold before it is accepted (>=1; 1 = no filtering).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- sig_in  input  CHANNELS  raw asynchronous inputs.
- mode  input  2*CHANNELS  per-channel edge_mode_t; channel i uses bits [2i+1:2i].
- clr  input  CHANNELS  per-channel clear of sticky and overflow.
- level  output  CHANNELS  debounced stable level.
- edg  output  CHANNELS  one-cycle edge pulse.
- sticky  output  CHANNELS  latched "edge seen" flag.
- overflow  output  CHANNELS  edge occurred while sticky was still set.
- any_edg  output  1  OR-reduction of edg.

Behaviour:
- Reset: on a clk edge with rst_n=0, all of the following go to 0: synchroniser flops, debounce counters, level, edg, sticky and overflow. any_edg is therefore 0. Reset asserted mid-operation aborts any in-progress debounce count.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; its last stage is sy[i].
- Debounce, per channel:
  - Counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If sy == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= sy and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of sy to level before acceptance restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never change level.
- Edge qualification, evaluated on the cycle level changes:
  - rise = 0->1, fall = 1->0.
  - Mode EDGE_OFF (00): no event.
  - EDGE_RISE (01): rise only.
  - EDGE_FALL (10): fall only.
  - EDGE_BOTH (11): either direction.
- edg is registered and updates on the same clk edge as level. It is high for exactly one cycle per accepted qualifying transition.
- Latency: number clock edges from 0, where edge 0 is the first edge at which sig_in holds its new value. level and edg update at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. edge 5 for the defaults.
- Sticky/overflow precedence, per channel, highest first:
  1. event and sticky=1 and clr=0: overflow <= 1.
  2. event: sticky <= 1. Set wins over a simultaneous clr; overflow is not set in that case and overflow is cleared by the clr.
  3. clr: sticky <= 0, overflow <= 0.
- Mode changes take effect for the next level change. level is tracked regardless of mode.
- After reset, a channel held high reports a rising edge once the latency has elapsed, because level resets to 0.
- Channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.
- any_edg is the combinational OR of the registered edg vector.

Decomposition:
- Package edge_detect_pkg holds:
  - typedef enum logic [1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH};
  - default parameter constants.
- Sub-module edge_detect_channel implements one channel: synchroniser, debounce counter, level, edg, sticky and overflow.
- The top level instantiates CHANNELS copies in a generate loop, slices mode, and ORs edg.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles with sig_in=8'hFF -> all outputs 0. Release reset -> edg=8'hFF on the single cycle after edge 5, then level=8'hFF and sticky=8'hFF.
- Glitch rejection: mode=RISE. Pulse sig_in[0] high for 3 cycles, then low -> edg[0], level[0] and sticky[0] stay 0. Hold it high for 4 cycles -> edg[0]=1 for exactly one cycle, latency 5 edges.
- Mode coverage: channels 0-3 set to OFF/RISE/FALL/BOTH; drive each high then low (stable 10 cycles each) -> edg pulses counted as 0, 1, 1 and 2 respectively. level follows the input on all four channels.
- Sticky/overflow: two rising edges on channel 2 with no clr -> sticky[2]=1, overflow[2]=1. Then clr[2]=1 for one cycle -> both 0.
- Set-wins collision: assert clr[5] on the same cycle edg[5] fires -> sticky[5]=1, overflow[5]=0.
- Mid-debounce reset: assert rst_n=0 after 2 of the 4 debounce cycles -> cnt cleared and no edg. After release, the full latency restarts from edge 0.
